rtc_field_sender: RTL
=====================

# rtc_field_sender

Transmit side of the RTC-to-display field link. It snapshots the nine BCD time fields (date, time-of-day, chronometer) and serialises them as (flag code, data byte) pairs on the 4-bit flag / 8-bit data interface. The display path decodes each flag code into a one-hot enable and latches the byte into its field register. The block sits between the RTC read/write controller and the display-side flag/data multiplexers.

## Interface
Parameters:
- HOLD_CYCLES, 2: DivCLK cycles each field stays on the bus (≥1).
- GAP_CYCLES, 1: DivCLK cycles of idle code (flag 0) after each field (≥1).

Ports:
- DivCLK  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  frame request; sampled each DivCLK edge.
- day_i, month_i, year_i  in  8 each  date fields, BCD.
- sec_i, min_i, hour_i  in  8 each  time-of-day fields, BCD.
- csec_i, cmin_i, chour_i  in  8 each  chronometer fields, BCD.
- flag_code  out  4  field code: 0 = idle, 1..9 = field (see Operation).
- data_out  out  8  field byte; 0x00 whenever flag_code = 0.
- busy  out  1  high from the first SEND cycle through the DONE cycle.
- done  out  1  one-cycle pulse at the end of a frame.
- bcd_err  out  1  sticky: a field with a nibble > 9 was sent. Cleared only by reset.

## Operation
- Code map, also the send order: 1 day, 2 month, 3 year, 4 sec, 5 min, 6 hour, 7 csec, 8 cmin, 9 chour.
- FSM states:
  - IDLE → SEND when start = 1. At that same edge all nine inputs are latched into the snapshot registers, idx = 0, and the hold counter is loaded.
  - SEND: flag_code = idx+1 and data_out = snapshot[idx] for HOLD_CYCLES cycles, then → GAP.
  - GAP: flag_code = 0 and data_out = 0 for GAP_CYCLES cycles. Then → SEND with idx+1 if idx < 8, else → DONE.
  - DONE: held for one cycle with done = 1. Then → SEND (new snapshot) if pending = 1, else → IDLE.
- Input stability: inputs are sampled only at the snapshot edge. Changes during a frame do not affect that frame.
- start while busy: sets pending (one level deep). Further starts while pending is set are absorbed. pending clears when the new frame's snapshot is taken.
- BCD check:
  - Applies to the snapshot byte when its SEND phase begins.
  - A nibble > 9 causes data_out = 0x00 for that field and sets bcd_err.
  - The flag code is still sent unchanged.
- idx is 4 bits, counts 0..8 and never wraps past 8.
- Counters are sized with $clog2 of the parameter plus 1.

## Timing
- All outputs are registered. They change only on DivCLK rising edges or on reset assertion.
- Reset values:
  - flag_code = 0, data_out = 0x00, busy = 0, done = 0, bcd_err = 0.
  - State = IDLE, pending = 0, snapshot = 0.
- Latency: start sampled at edge E0 → flag_code = 1 valid from E0 through E0+HOLD_CYCLES.
- Frame length: 9·(HOLD_CYCLES+GAP_CYCLES) cycles, then one DONE cycle. Defaults: fields occupy cycles 1–27 after E0 and done is high in cycle 28.
- Back-to-back frames (pending = 1): flag_code = 1 reappears on the cycle right after done. There are no extra idle cycles.
- Reset mid-frame: all outputs go to reset values immediately (asynchronous). pending is lost. No partial-frame done pulse is issued.
- Receiver contract: each non-zero code is stable for HOLD_CYCLES and is followed by at least one zero-code cycle, so the receiver may treat it as level or edge.

## Structure
- Shared package, reused by the display-side decoder: field code constants FLD_IDLE=0 … FLD_CHOUR=9, NUM_FIELDS=9, and the state encoding.
- Sub-module: bcd_check (combinational; 8-bit in → valid flag). It is the only natural split. The FSM, counters and snapshot bank stay in this module.

## Test plan
- Reset then a single start, with inputs 0x15,0x04,0x16,0x30,0x45,0x12,0x05,0x10,0x01 → codes 1..9 in order, each for 2 cycles with matching bytes, a zero code between fields, and done in cycle 28.
- Change all inputs to 0x99 one cycle after start → the frame still carries the original snapshot values.
- start pulsed at cycle 10 and again at cycle 12 of a frame → exactly one extra frame; flag_code = 1 on the cycle after done; no third frame.
- month_i = 0x1A → code 2 is sent with data 0x00 and bcd_err rises that cycle and stays high through later good frames.
- Reset asserted during code 5 → outputs zero asynchronously; no done pulse; a new start gives a full frame from code 1.
- HOLD_CYCLES = 1, GAP_CYCLES = 3 → each code lasts 1 cycle with 3 idle cycles after it; done at cycle 37.

Source files
------------

// File: rtl/rtc_field_sender_pkg.sv
// Shared definitions for the RTC-to-display field link: field codes, field count
// and the sender FSM state encoding. The display-side decoder imports this too.
package rtc_field_sender_pkg;

  localparam int NUM_FIELDS = 9;

  localparam logic [3:0] FLD_IDLE  = 4'd0;
  localparam logic [3:0] FLD_DAY   = 4'd1;
  localparam logic [3:0] FLD_MONTH = 4'd2;
  localparam logic [3:0] FLD_YEAR  = 4'd3;
  localparam logic [3:0] FLD_SEC   = 4'd4;
  localparam logic [3:0] FLD_MIN   = 4'd5;
  localparam logic [3:0] FLD_HOUR  = 4'd6;
  localparam logic [3:0] FLD_CSEC  = 4'd7;
  localparam logic [3:0] FLD_CMIN  = 4'd8;
  localparam logic [3:0] FLD_CHOUR = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Field index 0..8 maps onto wire codes 1..9.
  function automatic logic [3:0] field_code(input logic [3:0] idx);
    return idx + 4'd1;
  endfunction

endpackage

// File: rtl/rtc_field_sender_bcd_check.sv
// Combinational BCD validity test: both nibbles of the byte must be 0..9.
module rtc_field_sender_bcd_check (
  input  logic [7:0] byte_i,
  output logic       valid_o
);

  assign valid_o = (byte_i[7:4] <= 4'd9) && (byte_i[3:0] <= 4'd9);

endmodule

// File: rtl/rtc_field_sender.sv
// Snapshots the nine BCD time fields and serialises them as (flag code, byte)
// pairs, each held HOLD_CYCLES and followed by GAP_CYCLES of idle code.
module rtc_field_sender
  import rtc_field_sender_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       DivCLK,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] day_i,
  input  logic [7:0] month_i,
  input  logic [7:0] year_i,
  input  logic [7:0] sec_i,
  input  logic [7:0] min_i,
  input  logic [7:0] hour_i,
  input  logic [7:0] csec_i,
  input  logic [7:0] cmin_i,
  input  logic [7:0] chour_i,
  output logic [3:0] flag_code,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       bcd_err
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX  = 4'(NUM_FIELDS - 1);

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic [3:0]       flag_q, flag_d;
  logic [7:0]       data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [7:0] snap_q  [NUM_FIELDS];
  logic [7:0] snap_in [NUM_FIELDS];
  logic       snap_load;
  logic       start_frame;
  logic [3:0] nxt_idx;
  logic [7:0] chk_byte;
  logic       chk_valid;

  assign snap_in[0] = day_i;
  assign snap_in[1] = month_i;
  assign snap_in[2] = year_i;
  assign snap_in[3] = sec_i;
  assign snap_in[4] = min_i;
  assign snap_in[5] = hour_i;
  assign snap_in[6] = csec_i;
  assign snap_in[7] = cmin_i;
  assign snap_in[8] = chour_i;

  assign nxt_idx = idx_q + 4'd1;

  // A new frame checks the live day input (snapshot is taken on the same edge);
  // otherwise the next field's snapshot byte is checked as its SEND phase begins.
  always_comb begin
    chk_byte = 8'h00;
    if (state_q == ST_IDLE || state_q == ST_DONE) begin
      chk_byte = day_i;
    end else if (idx_q < LAST_IDX) begin
      chk_byte = snap_q[nxt_idx];
    end
  end

  rtc_field_sender_bcd_check u_bcd_check (
    .byte_i  (chk_byte),
    .valid_o (chk_valid)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    flag_d      = flag_q;
    data_d      = data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    snap_load   = 1'b0;
    start_frame = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start || pending_q) start_frame = 1'b1;
      end
      ST_SEND: begin
        if (start) pending_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
          flag_d  = FLD_IDLE;
          data_d  = 8'h00;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (start) pending_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (idx_q < LAST_IDX) begin
          state_d = ST_SEND;
          idx_d   = nxt_idx;
          cnt_d   = HOLD_LOAD;
          flag_d  = field_code(nxt_idx);
          data_d  = chk_valid ? chk_byte : 8'h00;
          err_d   = err_q | ~chk_valid;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        if (start || pending_q) begin
          start_frame = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Shared by a fresh start and a queued back-to-back frame.
    if (start_frame) begin
      state_d   = ST_SEND;
      idx_d     = 4'd0;
      cnt_d     = HOLD_LOAD;
      pending_d = 1'b0;
      snap_load = 1'b1;
      flag_d    = FLD_DAY;
      data_d    = chk_valid ? day_i : 8'h00;
      err_d     = err_q | ~chk_valid;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge DivCLK or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= 4'd0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      flag_q    <= FLD_IDLE;
      data_q    <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_FIELDS; i++) snap_q[i] <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      flag_q    <= flag_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      if (snap_load) begin
        for (int i = 0; i < NUM_FIELDS; i++) snap_q[i] <= snap_in[i];
      end
    end
  end

  assign flag_code = flag_q;
  assign data_out  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bcd_err   = err_q;

endmodule
